// File: rtl/rng_stim_pkg.sv
// Shared types and helper functions for the stimulus bank: mode encoding,
// maximal-length Galois tap table, per-channel seeds and observation folding.
package rng_stim_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic {
    BST_IDLE = 1'b0,
    BST_RUN  = 1'b1
  } burst_state_e;

  localparam int MAX_OBS_W = 256;

  // Right-shift Galois masks: bit (i-1) set for each x^i term of the polynomial.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       return 32'h00000006;
      4:       return 32'h0000000C;
      5:       return 32'h00000014;
      6:       return 32'h00000030;
      7:       return 32'h00000060;
      8:       return 32'h000000B8;
      9:       return 32'h00000110;
      10:      return 32'h00000240;
      11:      return 32'h00000500;
      12:      return 32'h00000E08;
      13:      return 32'h00001C80;
      14:      return 32'h00003802;
      15:      return 32'h00006000;
      16:      return 32'h0000D008;
      17:      return 32'h00012000;
      18:      return 32'h00020400;
      19:      return 32'h00072000;
      20:      return 32'h00090000;
      21:      return 32'h00140000;
      22:      return 32'h00300000;
      23:      return 32'h00420000;
      24:      return 32'h00E10000;
      25:      return 32'h01200000;
      26:      return 32'h02000023;
      27:      return 32'h04000013;
      28:      return 32'h09000000;
      29:      return 32'h14000000;
      30:      return 32'h20000029;
      31:      return 32'h48000000;
      32:      return 32'hA3000000;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] galois_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'h0);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_of(input int k, input int base, input int st,
                                          input int width);
    logic [63:0] v;
    v = 64'(base) + 64'(k) * 64'(st);
    v = v & ((64'd1 << width) - 64'd1);
    if (v == 64'd0) v = 64'd1;
    return v[31:0];
  endfunction

  function automatic logic [31:0] fold(input logic [MAX_OBS_W-1:0] obs, input int obs_w,
                                       input int misr_w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < MAX_OBS_W; i++) begin
      if (i < obs_w) r[5'(i % misr_w)] = r[5'(i % misr_w)] ^ obs[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_lfsr_lane.sv
// One Galois LFSR channel of the stimulus bank; advances only when adv is high.
module rng_lfsr_lane
  import rng_stim_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [WIDTH-1:0] state
);

  localparam logic [31:0] TAPS = lfsr_taps(WIDTH);

  logic [WIDTH-1:0] r_state;
  logic [31:0]      w_cur;
  logic [31:0]      w_nxt;

  always_comb begin
    w_cur              = '0;
    w_cur[WIDTH-1:0]   = r_state;
  end

  assign w_nxt = galois_step(w_cur, TAPS);

  // Bits above WIDTH stay zero because both the state and the mask fit in WIDTH.
  if (WIDTH < 32) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = ^w_nxt[31:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SEED;
    else if (adv) r_state <= w_nxt[WIDTH-1:0];
  end

  assign state = r_state;

endmodule

// File: rtl/rng_stim_bank.sv
// Multi-channel pseudo-random stimulus source with run modes and an observation
// MISR that keeps DUT outputs from being swept by implementation tools.
module rng_stim_bank
  import rng_stim_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int WIDTH      = 32,
  parameter int SEED_BASE  = 3,
  parameter int SEED_STEP  = 2,
  parameter int OBS_WIDTH  = 64,
  parameter int MISR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    step,
  input  logic                    start,
  input  logic [15:0]             burst_len,
  output logic [NUM_CH*WIDTH-1:0] stim_out,
  output logic                    stim_valid,
  output logic                    busy,
  input  logic [OBS_WIDTH-1:0]    obs_in,
  output logic [MISR_WIDTH-1:0]   signature,
  output logic                    prevent_sweep_node
);

  mode_e                 w_mode;
  burst_state_e          r_bst;
  burst_state_e          w_bst_nxt;
  logic [15:0]           r_cnt;
  logic [15:0]           w_cnt_nxt;
  logic                  w_busy;
  logic                  w_adv;
  logic                  r_valid;
  logic [MISR_WIDTH-1:0] r_sig;
  logic                  r_psn;
  logic [31:0]           w_sig_cur;
  logic [31:0]           w_sig_nxt;
  logic [MAX_OBS_W-1:0]  w_obs_ext;

  assign w_mode = mode_e'(mode);
  assign w_busy = (r_bst == BST_RUN);

  always_comb begin
    w_adv = 1'b0;
    case (w_mode)
      MODE_FREE:  w_adv = 1'b1;
      MODE_STEP:  w_adv = step;
      MODE_BURST: w_adv = w_busy;
      default:    w_adv = 1'b0;
    endcase
  end

  // Leaving BURST mid-run aborts the burst; the lanes simply stop advancing.
  always_comb begin
    w_bst_nxt = r_bst;
    w_cnt_nxt = r_cnt;
    case (r_bst)
      BST_IDLE: begin
        if (w_mode == MODE_BURST && start && burst_len != 16'd0) begin
          w_bst_nxt = BST_RUN;
          w_cnt_nxt = burst_len;
        end
      end
      BST_RUN: begin
        if (w_mode != MODE_BURST || r_cnt == 16'd1) begin
          w_bst_nxt = BST_IDLE;
          w_cnt_nxt = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    w_obs_ext                = '0;
    w_obs_ext[OBS_WIDTH-1:0] = obs_in;
    w_sig_cur                = '0;
    w_sig_cur[MISR_WIDTH-1:0] = r_sig;
  end

  assign w_sig_nxt = galois_step(w_sig_cur, lfsr_taps(MISR_WIDTH))
                   ^ fold(w_obs_ext, OBS_WIDTH, MISR_WIDTH);

  if (MISR_WIDTH < 32) begin : g_sig_pad
    logic w_unused_sig_hi;
    assign w_unused_sig_hi = ^w_sig_nxt[31:MISR_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bst   <= BST_IDLE;
      r_cnt   <= 16'd0;
      r_valid <= 1'b0;
      r_sig   <= '0;
      r_psn   <= 1'b0;
    end else begin
      r_bst   <= w_bst_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_adv;
      r_sig   <= w_sig_nxt[MISR_WIDTH-1:0];
      r_psn   <= ^r_sig;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    localparam logic [31:0] SEED_K = seed_of(k, SEED_BASE, SEED_STEP, WIDTH);
    rng_lfsr_lane #(
      .WIDTH (WIDTH),
      .SEED  (SEED_K[WIDTH-1:0])
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .adv   (w_adv),
      .state (stim_out[k*WIDTH +: WIDTH])
    );
  end

  assign stim_valid         = r_valid;
  assign busy               = w_busy;
  assign signature          = r_sig;
  assign prevent_sweep_node = r_psn;

endmodule
